// File: rtl/div4_restoring.sv
// div4_restoring: iterative unsigned restoring divider, one quotient bit per cycle.
// Latency: WIDTH cycles from acceptance to out_valid. A result is held in DONE until out_ready.
// Optional macro DIV4_EARLY_OUT_EN: a nonzero divisor larger than the dividend skips the iterations.
module div4_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_sh_q;        // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] prem_q;        // partial remainder; its top bit is always zero, so it is not stored
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q;
`ifdef DIV4_EARLY_OUT_EN
  logic             early_q;
`endif

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;

  // Trial operand: partial remainder shifted left with the next dividend bit appended.
  logic [WIDTH:0]   trial_p;
  logic [WIDTH-1:0] trial_d;
  logic             trial_borrow;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] q_sh_d;

  assign trial_p = {prem_q, q_sh_q[WIDTH-1]};

  // WIDTH+1-bit ripple-borrow subtract P - {0, divisor}; the top difference bit is never kept.
  always_comb begin
    logic br;
    logic pb;
    logic sb;
    trial_d = '0;
    br      = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      pb = trial_p[i];
      sb = (i < WIDTH) ? divisor_q[i] : 1'b0;
      if (i < WIDTH) begin
        trial_d[i] = pb ^ sb ^ br;
      end
      br = (~pb & sb) | (~(pb ^ sb) & br);
    end
    trial_borrow = br;
  end

  // Keep the difference when it did not borrow, otherwise restore P; the quotient bit is the inverse borrow.
  always_comb begin
    prem_d = trial_borrow ? trial_p[WIDTH-1:0] : trial_d;
    q_sh_d = {q_sh_q[WIDTH-2:0], ~trial_borrow};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      q_sh_q        <= '0;
      divisor_q     <= '0;
      prem_q        <= '0;
      cnt_q         <= '0;
      dbz_q         <= 1'b0;
`ifdef DIV4_EARLY_OUT_EN
      early_q       <= 1'b0;
`endif
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready_q is high throughout IDLE, so in_valid alone completes the handshake.
          if (in_valid) begin
            q_sh_q     <= dividend;
            divisor_q  <= divisor;
            prem_q     <= '0;
            cnt_q      <= '0;
            dbz_q      <= (divisor == '0);
`ifdef DIV4_EARLY_OUT_EN
            early_q    <= (divisor != '0) && (dividend < divisor);
`endif
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef DIV4_EARLY_OUT_EN
          if (early_q) begin
            // Divisor exceeds dividend: quotient is zero and the dividend is the remainder.
            quotient_q    <= '0;
            remainder_q   <= q_sh_q;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_DONE;
          end else
`endif
          begin
            q_sh_q <= q_sh_d;
            prem_q <= prem_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              quotient_q    <= q_sh_d;
              remainder_q   <= prem_d;
              div_by_zero_q <= dbz_q;
              out_valid_q   <= 1'b1;
              state_q       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
